hazard_ctrl_mc: RTL and testbench
=================================

Name: hazard_ctrl_mc

Overview:
Parametrised hazard/stall/flush controller for the 5-stage RV32 pipeline. It is the successor to the single-cycle combinational hazard unit.
- Keeps the existing three hazard classes: load-use, sub-word store read-modify-write (RMW), and redirect on a taken branch resolved in MEM.
- New: configurable multi-cycle load and RMW bubbles, a multi-cycle mul/div wait, x0/unused-operand filtering, and a stall-cycle performance counter.
- Sits beside the pipeline registers and drives their stall/flush and the PC mux.

Parameters:
- REG_W, 5, register-index width.
- LOAD_LAT, 1, load-use bubbles inserted (≥1).
- RMW_CYCLES, 1, extra cycles a sb/sh occupies the synchronous RAM (≥1).
- MULDIV_EN, 1, 0 ties the mul/div wait logic off; its inputs are ignored.
- PERF_W, 32, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rs1, rs2  in  REG_W  ID-stage source indices.
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2.
- ID_EX_memRead  in  1  EX holds a load.
- ID_EX_rd  in  REG_W  EX destination.
- ID_EX_memAccess  in  1  EX holds a load/store.
- ID_EX_muldiv  in  1  EX holds a multi-cycle mul/div.
- muldiv_done  in  1  mul/div result valid this cycle.
- EX_MEM_maskMode  in  2  00 byte, 01 half, 10 word.
- EX_MEM_wen  in  1  MEM holds a store.
- EX_MEM_taken  in  1  redirect required.
- pcFromTaken, pcStall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_flush  out  1  pipeline controls.
- busy  out  1  FSM not IDLE.
- stall_cycles  out  PERF_W  count of cycles with pcStall=1.

Behaviour:
- Reset: state IDLE, counter 0, stall_cycles 0. While rst=1, all control outputs are 0.
- Hazard conditions:
  - lu = ID_EX_memRead & ID_EX_rd≠0 & ((id_uses_rs1 & rd==rs1) | (id_uses_rs2 & rd==rs2)).
  - rmw = ID_EX_memAccess & EX_MEM_wen & maskMode∈{00,01}.
  - md = MULDIV_EN & ID_EX_muldiv & !muldiv_done.
- Output sets:
  - HOLD set: pcStall, IF_ID_stall, ID_EX_stall, EX_MEM_flush = 1.
  - BUBBLE set: pcStall, IF_ID_stall, ID_EX_flush = 1.
- States: IDLE, LOAD_WAIT, RMW_WAIT, MD_WAIT.
- IDLE, evaluated in priority order:
  - EX_MEM_taken → REDIRECT outputs. REDIRECT = pcFromTaken=1, IF_ID_flush=1, ID_EX_flush=1; every other output 0, including EX_MEM_flush and pcStall.
  - md → HOLD; next state MD_WAIT.
  - rmw → HOLD; if RMW_CYCLES>1, next state RMW_WAIT with cnt=RMW_CYCLES-1.
  - lu → BUBBLE; if LOAD_LAT>1, next state LOAD_WAIT with cnt=LOAD_LAT-1.
- MD_WAIT: HOLD while !muldiv_done. In the cycle muldiv_done=1, outputs follow IDLE evaluation and next state is IDLE (zero-cycle release).
- RMW_WAIT: HOLD. cnt decrements; at cnt==1, next state IDLE.
- LOAD_WAIT: BUBBLE. cnt decrements; at cnt==1, next state IDLE. lu is not re-armed by the bubble already in EX.
- Totals: exactly LOAD_LAT bubble cycles per load-use; exactly RMW_CYCLES hold cycles per sub-word store.
- EX_MEM_taken in any state: REDIRECT outputs that cycle; next state IDLE and cnt cleared (abort).
- HOLD and BUBBLE together: HOLD wins and ID_EX_flush is forced 0. The load-use is re-detected after release.
- Invariants:
  - ID_EX_stall and ID_EX_flush are never both 1.
  - pcFromTaken and pcStall are never both 1.
- Mid-operation reset: the next cycle is IDLE with all outputs 0.
- stall_cycles: +1 on each cycle pcStall=1, saturating at 2^PERF_W-1.

Decomposition:
- hazard_pkg holds:
  - the state enum (IDLE/LOAD_WAIT/RMW_WAIT/MD_WAIT);
  - maskMode constants MASK_B=00, MASK_H=01, MASK_W=10;
  - CNT_W = clog2(max(LOAD_LAT, RMW_CYCLES)+1).
- One natural sub-module: hazard_perf_cnt, the saturating stall counter.

Test Plan:
- LOAD_LAT=2: lw x5 in EX, add x6,x5,x1 in ID → pcStall/IF_ID_stall/ID_EX_flush high for exactly 2 cycles; busy=1 in cycle 2; stall_cycles=2.
- ID_EX_rd=0 with memRead, rs1=0; also rd=7, rs2=7 with id_uses_rs2=0 → no stall.
- RMW_CYCLES=3, sb in MEM, lw in EX → HOLD for 3 cycles. With lu also true in cycle 1, ID_EX_flush=0 throughout.
- MULDIV_EN=1: div in EX, muldiv_done after 5 cycles → HOLD 5 cycles, released in the done cycle. With MULDIV_EN=0, no stall.
- LOAD_LAT=3: EX_MEM_taken=1 in LOAD_WAIT cycle 2 → that cycle pcFromTaken=1, IF_ID_flush=ID_EX_flush=1, pcStall=0; next cycle IDLE, busy=0.
- rst asserted during MD_WAIT → next cycle all outputs 0, busy=0, stall_cycles=0. Saturation check with PERF_W=3 after 10 stall cycles → 7.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the multi-cycle hazard controller.
// Contents: FSM state enum, per-cycle action enum, maskMode encodings,
//           and a helper that sizes the wait counter from the parameters.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_WAIT  = 2'd2,
        MD_WAIT   = 2'd3
    } state_e;

    // What the controller does to the pipeline in the current cycle.
    typedef enum logic [1:0] {
        ACT_NONE   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_REDIR  = 2'd3
    } act_e;

    localparam logic [1:0] MASK_B = 2'b00;
    localparam logic [1:0] MASK_H = 2'b01;
    localparam logic [1:0] MASK_W = 2'b10;

    // Counter width: clog2(max(LOAD_LAT, RMW_CYCLES) + 1).
    function automatic int cnt_width(input int load_lat, input int rmw_cycles);
        int m;
        m = (load_lat > rmw_cycles) ? load_lat : rmw_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating performance counter: counts cycles where i_inc is high.
// Ports: clk, rst (sync, active-high), i_inc (count enable),
//        o_count (W-bit count, sticks at all-ones).
module hazard_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard/stall/flush controller for the 5-stage RV32 pipeline with multi-cycle waits.
// Inputs: ID source indices/uses, EX load/mem/muldiv info, MEM store mask/taken.
// Outputs: PC mux select, IF/ID and ID/EX stall/flush, EX/MEM flush, busy, stall counter.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int LOAD_LAT   = 1,
    parameter int RMW_CYCLES = 1,
    parameter int MULDIV_EN  = 1,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  rs1,
    input  logic [REG_W-1:0]  rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              ID_EX_memRead,
    input  logic [REG_W-1:0]  ID_EX_rd,
    input  logic              ID_EX_memAccess,
    input  logic              ID_EX_muldiv,
    input  logic              muldiv_done,
    input  logic [1:0]        EX_MEM_maskMode,
    input  logic              EX_MEM_wen,
    input  logic              EX_MEM_taken,
    output logic              pcFromTaken,
    output logic              pcStall,
    output logic              IF_ID_stall,
    output logic              IF_ID_flush,
    output logic              ID_EX_stall,
    output logic              ID_EX_flush,
    output logic              EX_MEM_flush,
    output logic              busy,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int CNT_W = cnt_width(LOAD_LAT, RMW_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] RMW_INIT  = CNT_W'(RMW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic             w_lu;
    logic             w_rmw;
    logic             w_md;
    act_e             w_idle_act;
    state_e           w_idle_next;
    logic [CNT_W-1:0] w_idle_cnt;
    act_e             w_act;

    // x0 and operands the ID instruction does not read never create a hazard.
    assign w_lu  = ID_EX_memRead && (ID_EX_rd != '0) &&
                   ((id_uses_rs1 && (ID_EX_rd == rs1)) ||
                    (id_uses_rs2 && (ID_EX_rd == rs2)));
    assign w_rmw = ID_EX_memAccess && EX_MEM_wen &&
                   ((EX_MEM_maskMode == MASK_B) || (EX_MEM_maskMode == MASK_H));
    assign w_md  = (MULDIV_EN != 0) && ID_EX_muldiv && !muldiv_done;

    // Fresh evaluation from IDLE; also reused in the mul/div release cycle.
    // Priority order makes HOLD win over BUBBLE, so ID_EX_flush stays 0 then.
    always_comb begin
        w_idle_act  = ACT_NONE;
        w_idle_next = IDLE;
        w_idle_cnt  = '0;
        if (EX_MEM_taken) begin
            w_idle_act = ACT_REDIR;
        end else if (w_md) begin
            w_idle_act  = ACT_HOLD;
            w_idle_next = MD_WAIT;
        end else if (w_rmw) begin
            w_idle_act = ACT_HOLD;
            if (RMW_CYCLES > 1) begin
                w_idle_next = RMW_WAIT;
                w_idle_cnt  = RMW_INIT;
            end
        end else if (w_lu) begin
            w_idle_act = ACT_BUBBLE;
            if (LOAD_LAT > 1) begin
                w_idle_next = LOAD_WAIT;
                w_idle_cnt  = LOAD_INIT;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic; a redirect aborts any wait in progress.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        if (EX_MEM_taken) begin
            w_next     = IDLE;
            w_cnt_next = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_next     = w_idle_next;
                    w_cnt_next = w_idle_cnt;
                end
                MD_WAIT: begin
                    if (muldiv_done) begin
                        w_next     = w_idle_next;
                        w_cnt_next = w_idle_cnt;
                    end
                end
                RMW_WAIT, LOAD_WAIT: begin
                    w_cnt_next = r_cnt - 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_next = IDLE;
                    end
                end
                default: begin
                    w_next     = IDLE;
                    w_cnt_next = '0;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        w_act = ACT_NONE;
        if (EX_MEM_taken) begin
            w_act = ACT_REDIR;
        end else begin
            case (r_state)
                IDLE:      w_act = w_idle_act;
                MD_WAIT:   w_act = muldiv_done ? w_idle_act : ACT_HOLD;
                RMW_WAIT:  w_act = ACT_HOLD;
                LOAD_WAIT: w_act = ACT_BUBBLE;
                default:   w_act = ACT_NONE;
            endcase
        end

        pcFromTaken  = 1'b0;
        pcStall      = 1'b0;
        IF_ID_stall  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_stall  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        busy         = 1'b0;
        if (!rst) begin
            busy = (r_state != IDLE);
            case (w_act)
                ACT_REDIR: begin
                    pcFromTaken = 1'b1;
                    IF_ID_flush = 1'b1;
                    ID_EX_flush = 1'b1;
                end
                ACT_HOLD: begin
                    pcStall      = 1'b1;
                    IF_ID_stall  = 1'b1;
                    ID_EX_stall  = 1'b1;
                    EX_MEM_flush = 1'b1;
                end
                ACT_BUBBLE: begin
                    pcStall     = 1'b1;
                    IF_ID_stall = 1'b1;
                    ID_EX_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    hazard_perf_cnt #(
        .W (PERF_W)
    ) u_perf_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (pcStall),
        .o_count (stall_cycles)
    );

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: two configurations driven with identical stimulus,
// each compared every cycle against a pending-work reference model.
module tb_hazard_ctrl_mc;

    localparam int L0 = 3, R0 = 3, M0 = 1, P0 = 32;
    localparam int L1 = 2, R1 = 1, M1 = 0, P1 = 3;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1, rs2, ID_EX_rd;
    logic       id_uses_rs1, id_uses_rs2;
    logic       ID_EX_memRead, ID_EX_memAccess, ID_EX_muldiv, muldiv_done;
    logic [1:0] EX_MEM_maskMode;
    logic       EX_MEM_wen, EX_MEM_taken;

    logic        pft0, pst0, ifs0, iff0, ies0, ief0, emf0, busy0;
    logic        pft1, pst1, ifs1, iff1, ies1, ief1, emf1, busy1;
    logic [31:0] sc0;
    logic [2:0]  sc1;
    logic [7:0]  ctl0, ctl1;

    // Bit order: pcFromTaken, pcStall, IF_ID_stall, IF_ID_flush,
    //            ID_EX_stall, ID_EX_flush, EX_MEM_flush, busy
    assign ctl0 = {pft0, pst0, ifs0, iff0, ies0, ief0, emf0, busy0};
    assign ctl1 = {pft1, pst1, ifs1, iff1, ies1, ief1, emf1, busy1};

    hazard_ctrl_mc #(.REG_W(5), .LOAD_LAT(L0), .RMW_CYCLES(R0), .MULDIV_EN(M0), .PERF_W(P0)) u0 (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ID_EX_memRead(ID_EX_memRead), .ID_EX_rd(ID_EX_rd),
        .ID_EX_memAccess(ID_EX_memAccess), .ID_EX_muldiv(ID_EX_muldiv),
        .muldiv_done(muldiv_done), .EX_MEM_maskMode(EX_MEM_maskMode),
        .EX_MEM_wen(EX_MEM_wen), .EX_MEM_taken(EX_MEM_taken),
        .pcFromTaken(pft0), .pcStall(pst0), .IF_ID_stall(ifs0), .IF_ID_flush(iff0),
        .ID_EX_stall(ies0), .ID_EX_flush(ief0), .EX_MEM_flush(emf0),
        .busy(busy0), .stall_cycles(sc0)
    );

    hazard_ctrl_mc #(.REG_W(5), .LOAD_LAT(L1), .RMW_CYCLES(R1), .MULDIV_EN(M1), .PERF_W(P1)) u1 (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ID_EX_memRead(ID_EX_memRead), .ID_EX_rd(ID_EX_rd),
        .ID_EX_memAccess(ID_EX_memAccess), .ID_EX_muldiv(ID_EX_muldiv),
        .muldiv_done(muldiv_done), .EX_MEM_maskMode(EX_MEM_maskMode),
        .EX_MEM_wen(EX_MEM_wen), .EX_MEM_taken(EX_MEM_taken),
        .pcFromTaken(pft1), .pcStall(pst1), .IF_ID_stall(ifs1), .IF_ID_flush(iff1),
        .ID_EX_stall(ies1), .ID_EX_flush(ief1), .EX_MEM_flush(emf1),
        .busy(busy1), .stall_cycles(sc1)
    );

    typedef struct {
        logic [7:0]  ctl0;
        logic [7:0]  ctl1;
        logic [31:0] cnt0;
        logic [31:0] cnt1;
        bit          chk_cnt;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model: outstanding work per configuration.
    int     load_left [2];
    int     rmw_left  [2];
    bit     md_wait   [2];
    longint mcnt      [2];

    localparam logic [7:0] O_HOLD   = 8'b0110_1010;
    localparam logic [7:0] O_BUBBLE = 8'b0110_0100;
    localparam logic [7:0] O_REDIR  = 8'b1001_0100;

    function automatic logic [7:0] model_step(input int k);
        logic [7:0] o;
        bit     pend, lu, rmw, md;
        int     ll, rc, me;
        longint cmax;
        ll   = (k == 0) ? L0 : L1;
        rc   = (k == 0) ? R0 : R1;
        me   = (k == 0) ? M0 : M1;
        cmax = (k == 0) ? 64'hFFFF_FFFF : 64'd7;
        pend = md_wait[k] || (rmw_left[k] > 0) || (load_left[k] > 0);
        if (rst) begin
            load_left[k] = 0; rmw_left[k] = 0; md_wait[k] = 0; mcnt[k] = 0;
            return 8'h00;
        end
        o   = {7'b0, pend};
        lu  = ID_EX_memRead && (ID_EX_rd != 0) &&
              ((id_uses_rs1 && ID_EX_rd == rs1) || (id_uses_rs2 && ID_EX_rd == rs2));
        rmw = ID_EX_memAccess && EX_MEM_wen && (EX_MEM_maskMode == 2'b00 || EX_MEM_maskMode == 2'b01);
        md  = (me != 0) && ID_EX_muldiv && !muldiv_done;
        if (EX_MEM_taken) begin
            o |= O_REDIR;
            load_left[k] = 0; rmw_left[k] = 0; md_wait[k] = 0;
        end else if (md_wait[k] && !muldiv_done) begin
            o |= O_HOLD;
        end else if (rmw_left[k] > 0) begin
            o |= O_HOLD;
            rmw_left[k]--;
        end else if (load_left[k] > 0) begin
            o |= O_BUBBLE;
            load_left[k]--;
        end else begin
            md_wait[k] = 0;
            if (md) begin
                o |= O_HOLD;
                md_wait[k] = 1;
            end else if (rmw) begin
                o |= O_HOLD;
                rmw_left[k] = rc - 1;
            end else if (lu) begin
                o |= O_BUBBLE;
                load_left[k] = ll - 1;
            end
        end
        if (o[6] && mcnt[k] < cmax) mcnt[k]++;
        return o;
    endfunction

    task automatic check(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, got, exp);
        end
    endtask

    // Push this cycle's expectation, then advance to just after the next edge.
    task automatic tick(input bit chk_cnt);
        exp_t e;
        e.cnt0    = 32'(mcnt[0]);
        e.cnt1    = 32'(mcnt[1]);
        e.ctl0    = model_step(0);
        e.ctl1    = model_step(1);
        e.chk_cnt = chk_cnt;
        e.cyc     = cyc;
        cyc++;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rst = 0; rs1 = 0; rs2 = 0; ID_EX_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0;
        ID_EX_memRead = 0; ID_EX_memAccess = 0; ID_EX_muldiv = 0; muldiv_done = 0;
        EX_MEM_maskMode = 2'b10; EX_MEM_wen = 0; EX_MEM_taken = 0;
    endtask

    task automatic set_lu();
        ID_EX_memRead = 1; ID_EX_memAccess = 1; ID_EX_rd = 5;
        rs1 = 5; id_uses_rs1 = 1; rs2 = 1; id_uses_rs2 = 1;
    endtask

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("ctl_u0", e.cyc, {24'b0, ctl0}, {24'b0, e.ctl0});
            check("ctl_u1", e.cyc, {24'b0, ctl1}, {24'b0, e.ctl1});
            check("stall_vs_flush_u0", e.cyc, {31'b0, ies0 & ief0}, 32'd0);
            check("taken_vs_stall_u1", e.cyc, {31'b0, pft1 & pst1}, 32'd0);
            if (e.chk_cnt) begin
                check("cnt_u0", e.cyc, sc0, e.cnt0);
                check("cnt_u1", e.cyc, {29'b0, sc1}, e.cnt1);
            end
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            load_left[k] = 0; rmw_left[k] = 0; md_wait[k] = 0; mcnt[k] = 0;
        end
        clr();
        rst = 1;
        tick(0);
        tick(1);

        // Load-use on x5: u0 bubbles 3 cycles, u1 bubbles 2.
        clr(); set_lu(); tick(1);
        clr(); repeat (4) tick(1);
        check("lu_total_u0", cyc, sc0, 32'd3);
        check("lu_total_u1", cyc, {29'b0, sc1}, 32'd2);

        // rd = x0, and an unused rs2 that matches rd: no stall.
        clr(); ID_EX_memRead = 1; ID_EX_rd = 0; rs1 = 0; id_uses_rs1 = 1; tick(1);
        clr(); ID_EX_memRead = 1; ID_EX_rd = 7; rs2 = 7; id_uses_rs2 = 0;
        rs1 = 3; id_uses_rs1 = 1; tick(1);

        // Byte store in MEM with a load-use pending in the first cycle.
        clr(); set_lu(); EX_MEM_wen = 1; EX_MEM_maskMode = 2'b00; tick(1);
        clr(); repeat (4) tick(1);
        // Half store with load-use held: re-detected once the hold releases.
        clr(); set_lu(); EX_MEM_wen = 1; EX_MEM_maskMode = 2'b01; tick(1);
        EX_MEM_wen = 0; repeat (3) tick(1);
        clr(); repeat (4) tick(1);
        // Word store: no RMW.
        clr(); ID_EX_memAccess = 1; EX_MEM_wen = 1; EX_MEM_maskMode = 2'b10; tick(1);

        // Divide finishing after 5 cycles, released in the done cycle.
        clr(); ID_EX_muldiv = 1; repeat (5) tick(1);
        muldiv_done = 1; tick(1);
        clr(); repeat (2) tick(1);

        // Redirect in the second bubble cycle aborts the wait.
        clr(); set_lu(); tick(1);
        clr(); EX_MEM_taken = 1; tick(1);
        clr(); repeat (3) tick(1);

        // Reset in the middle of a mul/div wait.
        clr(); ID_EX_muldiv = 1; repeat (3) tick(1);
        rst = 1; tick(1);
        check("rst_cnt_u0", cyc, sc0, 32'd0);
        check("rst_cnt_u1", cyc, {29'b0, sc1}, 32'd0);
        clr(); ID_EX_muldiv = 1; tick(1);
        clr(); repeat (2) tick(1);

        // Saturation of the 3-bit counter.
        clr(); rst = 1; tick(1);
        for (int i = 0; i < 10; i++) begin
            clr(); set_lu(); tick(1);
            clr(); repeat (2) tick(1);
        end
        check("sat_u1", cyc, {29'b0, sc1}, 32'd7);
        check("sat_u0", cyc, sc0, 32'd30);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 99) == 0);
            rs1             = 5'($urandom_range(0, 3));
            rs2             = 5'($urandom_range(0, 3));
            ID_EX_rd        = 5'($urandom_range(0, 3));
            id_uses_rs1     = ($urandom_range(0, 3) != 0);
            id_uses_rs2     = ($urandom_range(0, 3) != 0);
            ID_EX_memRead   = ($urandom_range(0, 2) == 0);
            ID_EX_memAccess = ID_EX_memRead | ($urandom_range(0, 3) == 0);
            ID_EX_muldiv    = ($urandom_range(0, 5) == 0);
            muldiv_done     = ($urandom_range(0, 3) == 0);
            EX_MEM_maskMode = 2'($urandom_range(0, 3));
            EX_MEM_wen      = ($urandom_range(0, 2) == 0);
            EX_MEM_taken    = ($urandom_range(0, 19) == 0);
            tick(1);
        end
        clr();

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
